// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_t    : loader FSM states (also exported on the debug port)
//   BYTE_W     : stream byte width
//   LANES      : bytes per instruction word
//   WORD_W     : assembled word width
//   LANE_IDX_W : width of the byte-lane index
package loader_pkg;
    localparam int BYTE_W     = 8;
    localparam int LANES      = 4;
    localparam int WORD_W     = BYTE_W * LANES;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between a producer and the loader.
//   byte_valid_i : producer has a byte on byte_i
//   byte_i       : stream byte
//   byte_ready_o : loader accepts byte_i this cycle
// Handshake: a byte transfers on a rising edge where byte_valid_i && byte_ready_o.
// The producer keeps byte_i stable and byte_valid_i high until the transfer;
// byte_ready_o never depends combinationally on byte_valid_i.
interface imem_loader_if;
    import loader_pkg::*;

    logic              byte_valid_i;
    logic [BYTE_W-1:0] byte_i;
    logic              byte_ready_o;

    modport master (output byte_valid_i, output byte_i, input byte_ready_o);
    modport slave  (input byte_valid_i, input byte_i, output byte_ready_o);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four stream bytes into a little-endian word.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : restart assembly at lane 0 (wins over accept_i)
//   accept_i     : byte_i is consumed into the current lane
//   byte_i       : incoming byte
//   word_o       : stored lanes with byte_i merged into the current lane,
//                  so on the final accept it is already the complete word
//   last_byte_o  : the current lane is the top lane
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_byte_o
);
    logic [LANE_IDX_W-1:0] idx_q, idx_d;
    logic [WORD_W-1:0]     word_q, word_d;

    always_comb begin
        word_o = word_q;
        word_o[{idx_q, 3'b000} +: BYTE_W] = byte_i;
    end

    assign last_byte_o = (idx_q == LANE_IDX_W'(LANES - 1));

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
        end else if (accept_i) begin
            idx_d  = idx_q + LANE_IDX_W'(1);
            word_d = word_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader. Parses a frame (count N, 4*N little-endian data
// bytes, XOR checksum), writes each word into instruction memory and holds the
// core in reset until a frame has loaded with a good checksum.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : restart a load from the header (wins over a same-cycle byte)
//   bs           : byte-stream handshake (slave side)
//   we_o, waddr_o, wdata_o : instruction memory write port
//   cpu_rst_o    : core reset, low only after a clean load
//   done_o       : frame loaded, checksum good
//   err_o        : frame rejected
//   dbg_state_o  : current FSM state
module imem_loader
    import loader_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NUMWORDS  = 32,
    parameter int ADDRWIDTH = $clog2(NUMWORDS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    imem_loader_if.slave         bs,
    output logic                 we_o,
    output logic [ADDRWIDTH-1:0] waddr_o,
    output logic [DATAWIDTH-1:0] wdata_o,
    output logic                 cpu_rst_o,
    output logic                 done_o,
    output logic                 err_o,
    output state_t               dbg_state_o
);
    state_t                state_q, state_d;
    logic [ADDRWIDTH-1:0]  last_q, last_d;    // N-1: address of the final word
    logic [ADDRWIDTH-1:0]  addr_q, addr_d;
    logic [BYTE_W-1:0]     csum_q, csum_d;
    logic [ADDRWIDTH-1:0]  waddr_q, waddr_d;
    logic [DATAWIDTH-1:0]  wdata_q, wdata_d;

    logic              ready;
    logic              hs;
    logic              hdr_bad;
    logic              pk_clear;
    logic              pk_accept;
    logic [WORD_W-1:0] pk_word;
    logic              pk_last;

    // Ready is a pure state decode, so it never follows byte_valid_i.
    assign ready   = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign hs      = bs.byte_valid_i && ready;
    assign hdr_bad = (bs.byte_i == '0) || (int'({24'b0, bs.byte_i}) > NUMWORDS);

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (pk_clear),
        .accept_i    (pk_accept),
        .byte_i      (bs.byte_i),
        .word_o      (pk_word),
        .last_byte_o (pk_last)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        addr_d    = addr_q;
        csum_d    = csum_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        pk_clear  = 1'b0;
        pk_accept = 1'b0;

        if (start_i) begin
            // Any byte handshaking this cycle is dropped.
            state_d  = ST_HDR;
            pk_clear = 1'b1;
        end else begin
            unique case (state_q)
                ST_HDR: begin
                    if (hs) begin
                        if (hdr_bad) begin
                            state_d = ST_ERR;
                        end else begin
                            last_d   = ADDRWIDTH'(bs.byte_i - 8'd1);
                            addr_d   = '0;
                            csum_d   = bs.byte_i;
                            pk_clear = 1'b1;
                            state_d  = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (hs) begin
                        pk_accept = 1'b1;
                        csum_d    = csum_q ^ bs.byte_i;
                        if (pk_last) begin
                            // Capture the port values now so they hold after WRITE.
                            waddr_d = addr_q;
                            wdata_d = pk_word;
                            state_d = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (addr_q == last_q) begin
                        state_d = ST_CSUM;
                    end else begin
                        addr_d  = addr_q + ADDRWIDTH'(1);
                        state_d = ST_DATA;
                    end
                end
                ST_CSUM: begin
                    if (hs) begin
                        state_d = (bs.byte_i == csum_q) ? ST_DONE : ST_ERR;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_HDR;
            last_q  <= '0;
            addr_q  <= '0;
            csum_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            csum_q  <= csum_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bs.byte_ready_o = ready;
    assign we_o            = (state_q == ST_WRITE);
    assign waddr_o         = waddr_q;
    assign wdata_o         = wdata_q;
    assign done_o          = (state_q == ST_DONE);
    assign err_o           = (state_q == ST_ERR);
    assign cpu_rst_o       = (state_q != ST_DONE);
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    import loader_pkg::*;

    localparam int AW = 5;
    localparam int W  = AW + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    imem_loader_if bs ();

    logic          we_o;
    logic [AW-1:0] waddr_o;
    logic [31:0]   wdata_o;
    logic          cpu_rst_o, done_o, err_o;
    state_t        dbg_state;

    imem_loader #(.DATAWIDTH(32), .NUMWORDS(32), .ADDRWIDTH(AW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .bs          (bs),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o),
        .cpu_rst_o   (cpu_rst_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           wr_cyc_q[$];
    logic [7:0]   frame_q[$];
    logic [31:0]  words[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Walks the first nsent bytes of frame_q by the frame rules, queues every
    // word that is complete, and returns 0 = unfinished, 1 = done, 2 = error.
    function automatic int model_expect(input int nsent);
        int n;
        logic [7:0] c;
        n = int'(frame_q[0]);
        if (n == 0 || n > 32) return 2;
        c = frame_q[0];
        for (int k = 0; k < n; k++) begin
            if (1 + 4 * k + 4 <= nsent)
                exp_q.push_back({AW'(k), frame_q[4*k+4], frame_q[4*k+3], frame_q[4*k+2], frame_q[4*k+1]});
        end
        for (int i = 1; i <= 4 * n; i++) c = c ^ frame_q[i];
        if (nsent < 4 * n + 2) return 0;
        return (frame_q[4*n+1] == c) ? 1 : 2;
    endfunction

    // Header + words (LSB first) + XOR checksum, with an optional corruption.
    function automatic logic [7:0] build_frame(input int n, input logic [7:0] corrupt);
        logic [7:0] c;
        frame_q = {};
        frame_q.push_back(8'(n));
        c = 8'(n);
        for (int k = 0; k < n; k++) begin
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(words[k][8*b +: 8]);
                c = c ^ words[k][8*b +: 8];
            end
        end
        frame_q.push_back(c ^ corrupt);
        return c;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (we_o === 1'b1) begin
            check("ready_low_in_write", 64'(bs.byte_ready_o), 64'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write", waddr_o, wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("write_addr_data", 64'({waddr_o, wdata_o}), 64'(e));
            end
            wr_cyc_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, output int hs_c);
        int gap;
        int guard;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        repeat (gap) begin
            bs.byte_valid_i = 1'b0;
            @(posedge clk); #1;
        end
        bs.byte_valid_i = 1'b1;
        bs.byte_i = b;
        hs_c = -1;
        guard = 0;
        while (hs_c < 0 && guard < 64) begin
            @(negedge clk);
            if (bs.byte_ready_o === 1'b1) hs_c = cyc;
            @(posedge clk); #1;
            guard++;
        end
        check("byte_accepted", 64'(hs_c >= 0), 64'd1);
    endtask

    task automatic run_frame(input int nsent, input int max_gap, input bit do_start,
                             output int outcome, output int hdr_c);
        int c;
        outcome = model_expect(nsent);
        if (do_start) pulse_start();
        hdr_c = -1;
        for (int i = 0; i < nsent; i++) begin
            send_byte(frame_q[i], max_gap, c);
            if (i == 0) hdr_c = c;
        end
        bs.byte_valid_i = 1'b0;
    endtask

    // Checked in the cycle right after the last handshake.
    task automatic check_outcome(input string tag, input int outcome, input int hdr_c, input int exp_done_cyc);
        @(negedge clk);
        check({tag, "_done"}, 64'(done_o), 64'(outcome == 1));
        check({tag, "_err"}, 64'(err_o), 64'(outcome == 2));
        check({tag, "_cpu_rst"}, 64'(cpu_rst_o), 64'(outcome != 1));
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        if (exp_done_cyc >= 0) check({tag, "_done_cycle"}, 64'(cyc - hdr_c), 64'(exp_done_cyc));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 64'(dbg_state), 64'(ST_HDR));
        check({tag, "_ready"}, 64'(bs.byte_ready_o), 64'd1);
        check({tag, "_cpu_rst"}, 64'(cpu_rst_o), 64'd1);
        check({tag, "_we"}, 64'(we_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_waddr"}, 64'(waddr_o), 64'd0);
        check({tag, "_wdata"}, 64'(wdata_o), 64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int oc, hc;
        logic [7:0] cs;

        bs.byte_valid_i = 1'b0;
        bs.byte_i = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Good single word, frame given byte by byte.
        frame_q = '{8'h01, 8'h13, 8'h00, 8'h20, 8'h01, 8'h33};
        oc = model_expect(6);
        check("model_single_word", 64'(exp_q[0]), 64'({5'd0, 32'h0120_0013}));
        check("model_single_outcome", 64'(oc), 64'd1);
        exp_q = {};
        run_frame(6, 0, 1'b0, oc, hc);
        check_outcome("single", oc, hc, 7);

        // Full memory: 32 words, 5 cycles per word.
        words = {};
        for (int k = 0; k < 32; k++) words.push_back(32'hA500_0000 | k);
        cs = build_frame(32, 8'h00);
        check("model_full_csum", 64'(cs), 64'h20);
        wr_cyc_q = {};
        run_frame(4 * 32 + 2, 0, 1'b1, oc, hc);
        check_outcome("full", oc, hc, 162);
        check("full_write_count", 64'(wr_cyc_q.size()), 64'd32);
        for (int k = 0; k < 32 && k < wr_cyc_q.size(); k++)
            check("full_write_cycle", 64'(wr_cyc_q[k] - hc), 64'(5 * (k + 1)));

        // Bad headers: rejected after one handshake with no writes.
        frame_q = '{8'h00};
        run_frame(1, 0, 1'b1, oc, hc);
        check_outcome("hdr_zero", oc, hc, -1);
        frame_q = '{8'd33};
        run_frame(1, 0, 1'b1, oc, hc);
        check_outcome("hdr_33", oc, hc, -1);

        // Bad checksum: the word is still written.
        frame_q = '{8'h01, 8'h13, 8'h00, 8'h20, 8'h01, 8'h34};
        run_frame(6, 0, 1'b1, oc, hc);
        check("model_bad_csum_outcome", 64'(oc), 64'd2);
        check_outcome("bad_csum", oc, hc, -1);

        // Back-pressure on an N=2 frame.
        words = '{32'h1122_3344, 32'hDEAD_BEEF};
        cs = build_frame(2, 8'h00);
        run_frame(10, 3, 1'b1, oc, hc);
        check_outcome("backpressure", oc, hc, -1);

        // Abort after 6 data bytes of N=3; the start cycle also carries a byte.
        words = '{32'h0000_1111, 32'h0000_2222, 32'h0000_3333};
        cs = build_frame(3, 8'h00);
        run_frame(7, 0, 1'b1, oc, hc);
        start = 1'b1;
        bs.byte_valid_i = 1'b1;
        bs.byte_i = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        bs.byte_valid_i = 1'b0;
        @(negedge clk);
        check("abort_state", 64'(dbg_state), 64'(ST_HDR));
        check("abort_pending_writes", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
        words = '{32'hCAFE_F00D};
        cs = build_frame(1, 8'h00);
        run_frame(6, 0, 1'b0, oc, hc);
        check_outcome("reload", oc, hc, 7);

        // start_i in DONE drops the core back into reset.
        pulse_start();
        @(negedge clk);
        check("restart_cpu_rst", 64'(cpu_rst_o), 64'd1);
        check("restart_done", 64'(done_o), 64'd0);
        check("restart_ready", 64'(bs.byte_ready_o), 64'd1);
        @(posedge clk); #1;

        // Reset asserted during WRITE.
        words = '{32'hDDCC_BBAA};
        cs = build_frame(1, 8'h00);
        run_frame(5, 0, 1'b1, oc, hc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("rst_mid_write");
        check("rst_mid_write_pending", 64'(exp_q.size()), 64'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
